// File: rtl/slot_reel_controller.sv
`default_nettype none
// ============================================================================
// Module   : slot_reel_controller
// Purpose  : Captures three stop symbols from the random stream on a spin
//            request, animates three 8-symbol reels at a divided step rate,
//            stops them in a staggered order on their targets, then registers
//            a payout class and pulses done.
// Revision : 1.0 - initial release
// ============================================================================
module slot_reel_controller #(
  parameter int STEP_DIV  = 4,
  parameter int MIN_TURNS = 8,
  parameter int STAGGER   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spin,
  input  logic [2:0] rnd,
  output logic [2:0] reel0,
  output logic [2:0] reel1,
  output logic [2:0] reel2,
  output logic       busy,
  output logic       done,
  output logic [1:0] win
);

  // A divider of 1 still needs a one-bit counter that simply stays at zero.
  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(STEP_DIV - 1);

  // Earliest step index at which each reel is allowed to stop.
  localparam logic [7:0] c_thr [3] = '{8'(MIN_TURNS),
                                       8'(MIN_TURNS + STAGGER),
                                       8'(MIN_TURNS + 2 * STAGGER)};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CAP0 = 3'd1,
    CAP1 = 3'd2,
    CAP2 = 3'd3,
    SPIN = 3'd4,
    EVAL = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [DIV_W-1:0] r_div;
  logic [7:0]       r_step;
  logic [2:0]       r_reel   [3];
  logic [2:0]       r_target [3];
  logic [2:0]       r_stop;
  logic             r_done;
  logic [1:0]       r_win;

  logic             w_step;
  logic [2:0]       w_stop_next;
  logic [2:0]       w_reel_next [3];
  logic [1:0]       w_win;

  // Step strobe plus per-reel stop decision / advance for the current step.
  always_comb begin
    w_step      = (r_state == SPIN) && (r_div == c_div_last);
    w_stop_next = r_stop;
    for (int i = 0; i < 3; i++) begin
      w_reel_next[i] = r_reel[i];
      if (!r_stop[i]) begin
        if ((r_step >= c_thr[i]) && (r_reel[i] == r_target[i])) begin
          w_stop_next[i] = 1'b1;
        end else begin
          w_reel_next[i] = r_reel[i] + 3'd1;
        end
      end
    end
  end

  // Payout class from the settled reel symbols.
  always_comb begin
    w_win = 2'd0;
    if ((r_reel[0] == r_reel[1]) && (r_reel[1] == r_reel[2])) begin
      w_win = (r_reel[0] == 3'd7) ? 2'd3 : 2'd2;
    end else if ((r_reel[0] == r_reel[1]) || (r_reel[1] == r_reel[2]) ||
                 (r_reel[0] == r_reel[2])) begin
      w_win = 2'd1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; spin only matters while idle, so requests never queue.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (spin) w_state_next = CAP0;
      CAP0:    w_state_next = CAP1;
      CAP1:    w_state_next = CAP2;
      CAP2:    w_state_next = SPIN;
      SPIN:    if (w_step && (&w_stop_next)) w_state_next = EVAL;
      EVAL:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: target capture, divider, step counter, reels, result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        r_reel[i]   <= '0;
        r_target[i] <= '0;
      end
      r_div  <= '0;
      r_step <= '0;
      r_stop <= '0;
      r_done <= 1'b0;
      r_win  <= '0;
    end else begin
      r_done <= (r_state == EVAL);
      case (r_state)
        CAP0: r_target[0] <= rnd;
        CAP1: r_target[1] <= rnd;
        CAP2: begin
          r_target[2] <= rnd;
          r_div       <= '0;
          r_step      <= '0;
          r_stop      <= '0;
        end
        SPIN: begin
          if (w_step) begin
            r_div  <= '0;
            r_step <= r_step + 8'd1;
            r_stop <= w_stop_next;
            for (int i = 0; i < 3; i++) begin
              r_reel[i] <= w_reel_next[i];
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        EVAL:    r_win <= w_win;
        default: ;
      endcase
    end
  end

  assign reel0 = r_reel[0];
  assign reel1 = r_reel[1];
  assign reel2 = r_reel[2];
  assign busy  = (r_state != IDLE);
  assign done  = r_done;
  assign win   = r_win;

endmodule
`default_nettype wire

// File: tb/tb_slot_reel_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_slot_reel_controller
// Purpose  : Self-checking bench for slot_reel_controller: table of spin
//            vectors, hand-written reset/hold sequences and random spins
//            compared against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_slot_reel_controller;

  localparam int STEP_DIV  = 4;
  localparam int MIN_TURNS = 8;
  localparam int STAGGER   = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       spin;
  logic [2:0] rnd;
  logic [2:0] reel0, reel1, reel2;
  logic       busy, done;
  logic [1:0] win;

  int total = 0;
  int bad   = 0;

  // Reference model state: settled reel symbols and last payout class.
  int m_reel [3];
  int m_win;

  typedef struct {
    bit do_reset;
    int t0, t1, t2;
    int win;
    int lat;    // edges from spin-accept to done cycle, -1 = from model
    bit hold;   // keep spin high through the whole spin
    bit wrap;   // require every reel to be seen wrapping 7->0
  } vec_t;

  vec_t vecs [6];

  slot_reel_controller #(
    .STEP_DIV (STEP_DIV),
    .MIN_TURNS(MIN_TURNS),
    .STAGGER  (STAGGER)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .spin (spin),
    .rnd  (rnd),
    .reel0(reel0),
    .reel1(reel1),
    .reel2(reel2),
    .busy (busy),
    .done (done),
    .win  (win)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // First step index at which a reel starting at 'start' sits on 'tgt'
  // at or beyond its threshold; before stopping it shows (start+k) mod 8.
  function automatic int stop_step(int start, int tgt, int idx);
    int k;
    k = MIN_TURNS + idx * STAGGER;
    while (((start + k) % 8) != tgt) k++;
    return k;
  endfunction

  function automatic int model_win(int a, int b, int c);
    int pairs;
    pairs = int'(a == b) + int'(b == c) + int'(a == c);
    if (pairs == 3) return (a == 7) ? 3 : 2;
    if (pairs >= 1) return 1;
    return 0;
  endfunction

  task automatic apply_reset(input string tag);
    rst  = 1'b1;
    spin = 1'b0;
    tick;
    check({tag, " rst reel0"}, 32'(reel0), 0);
    check({tag, " rst reel1"}, 32'(reel1), 0);
    check({tag, " rst reel2"}, 32'(reel2), 0);
    check({tag, " rst busy"},  32'(busy),  0);
    check({tag, " rst done"},  32'(done),  0);
    check({tag, " rst win"},   32'(win),   0);
    tick;
    rst = 1'b0;
    m_reel = '{0, 0, 0};
    m_win  = 0;
  endtask

  task automatic run_spin(input int t0, input int t1, input int t2, input int want_win,
                          input int want_lat, input bit hold, input bit want_wrap,
                          input string tag);
    int tg [3];
    int prev [3];
    int cur [3];
    int fin, lat, n, errs;
    bit [2:0] wrap;
    bit seen;
    tg  = '{t0, t1, t2};
    fin = 0;
    for (int i = 0; i < 3; i++) begin
      int s;
      s = stop_step(m_reel[i], tg[i], i);
      if (s > fin) fin = s;
    end
    lat = (want_lat >= 0) ? want_lat : 4 + STEP_DIV * (fin + 1);

    spin = 1'b1;
    tick;                                   // edge E: spin accepted
    check({tag, " busy after accept"}, 32'(busy), 1);
    check({tag, " done after accept"}, 32'(done), 0);
    if (!hold) spin = 1'b0;
    rnd = 3'(t0); tick;
    rnd = 3'(t1); tick;
    rnd = 3'(t2); tick;                     // edge E+3
    n    = 3;
    errs = 0;
    wrap = '0;
    seen = 1'b0;
    prev = m_reel;
    while (n < lat + 20) begin
      rnd = 3'($urandom_range(0, 7));
      tick;
      n++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (!busy || (int'(win) != m_win)) errs++;
      cur = '{int'(reel0), int'(reel1), int'(reel2)};
      for (int i = 0; i < 3; i++) if (prev[i] == 7 && cur[i] == 0) wrap[i] = 1'b1;
      prev = cur;
    end
    check({tag, " done seen"},   32'(seen), 1);
    check({tag, " latency"},     32'(n),    32'(lat));
    check({tag, " busy/win hold during spin errs"}, 32'(errs), 0);
    check({tag, " busy in done cycle"}, 32'(busy), 0);
    check({tag, " reel0"}, 32'(reel0), 32'(t0));
    check({tag, " reel1"}, 32'(reel1), 32'(t1));
    check({tag, " reel2"}, 32'(reel2), 32'(t2));
    check({tag, " win"},   32'(win),   32'(want_win));
    if (want_wrap) check({tag, " wrap 7->0 mask"}, 32'(wrap), 7);
    m_reel = tg;
    m_win  = want_win;
  endtask

  initial begin
    int t [3];
    int quiet;
    vecs[0] = '{1'b1, 0, 0, 0, 2,  72, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 7, 7, 7, 3, 100, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1, 1, 2, 1,  -1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 3, 5, 6, 0,  -1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 2, 2, 2, 2,  -1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 4, 6, 4, 1,  -1, 1'b0, 1'b0};

    rst  = 1'b1;
    spin = 1'b0;
    rnd  = 3'd0;
    m_reel = '{0, 0, 0};
    m_win  = 0;
    apply_reset("init");

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].do_reset) apply_reset($sformatf("vec%0d", v));
      run_spin(vecs[v].t0, vecs[v].t1, vecs[v].t2, vecs[v].win, vecs[v].lat,
               vecs[v].hold, vecs[v].wrap, $sformatf("vec%0d", v));
    end
    spin = 1'b0;

    // Abort a spin at step 10 with reset, then confirm a clean restart.
    tick;
    spin = 1'b1;
    tick;                                   // edge E
    spin = 1'b0;
    rnd = 3'd5; tick;
    rnd = 3'd2; tick;
    rnd = 3'd6; tick;                       // edge E+3
    repeat (STEP_DIV * 11) tick;            // through step 10
    apply_reset("abort");
    quiet = 0;
    repeat (6) begin
      tick;
      if (done || busy) quiet++;
    end
    check("abort no done/busy after reset", 32'(quiet), 0);
    run_spin(0, 0, 0, 2, 72, 1'b0, 1'b0, "after-abort");

    // Random spins against the reference model.
    for (int r = 0; r < 12; r++) begin
      bit h;
      for (int i = 0; i < 3; i++) t[i] = int'($urandom_range(0, 7));
      h = (r < 11) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_spin(t[0], t[1], t[2], model_win(t[0], t[1], t[2]), -1, h, 1'b0,
               $sformatf("rand%0d", r));
    end
    spin = 1'b0;
    tick;
    check("final done cleared", 32'(done), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/slot_reel_controller.md
Name: slot_reel_controller

Overview:
- Consumer side of the slots random source.
- On a spin request it samples the 3-bit random stream on three consecutive cycles to pick one stop symbol per reel.
- It then animates three reels (symbols 0-7) that advance at a divided rate and stop one after another on their targets.
- It registers a payout class and pulses done; it sits between the random generator and the display/payout logic.

Parameters:
- STEP_DIV, 4, clock cycles per reel step (>=1).
- MIN_TURNS, 8, minimum steps before reel0 may stop.
- STAGGER, 4, extra minimum steps per reel index (reel i threshold = MIN_TURNS + i*STAGGER).
- Constraint: MIN_TURNS + 2*STAGGER + 8 < 256.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- spin  input  1  spin request, sampled only when idle.
- rnd  input  3  random symbol from the generator, may change every cycle.
- reel0  output  3  current symbol of reel 0.
- reel1  output  3  current symbol of reel 1.
- reel2  output  3  current symbol of reel 2.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse: result valid.
- win  output  2  payout class, held until the next result.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; reel0/1/2=0; targets=0; div/step counters=0; stop flags=0; busy=0; done=0; win=0. Applies in any state and aborts a spin in progress; no done pulse is produced.
- IDLE:
  - spin=1 -> CAP0. spin=0 -> stay.
  - spin is ignored in every other state; no queuing.
- CAP0/CAP1/CAP2: on each edge, target0/target1/target2 <= rnd respectively.
- CAP2 -> SPIN: clears the div counter, step counter and stop flags.
- SPIN:
  - The div counter counts 0..STEP_DIV-1 and wraps. The edge where div==STEP_DIV-1 is a step.
  - At step k (k = step count before increment), for each reel i not yet stopped:
    - if k >= MIN_TURNS + i*STAGGER and reel_i == target_i -> set stop_i; the reel holds.
    - otherwise reel_i <= reel_i + 1 mod 8 (7 wraps to 0).
  - Stopped reels hold. Several reels may stop on the same step. The step counter increments every step.
  - When all three stop flags would be set after this step -> EVAL.
- Reels are not reset between spins; each spin starts from the previous result.
- Each reel stops within 7 steps after its threshold, so the step count stays bounded.
- EVAL (one cycle): win and done register, state -> IDLE.
  - win = 3 if all reels equal and == 7.
  - win = 2 if all reels equal and != 7.
  - win = 1 if exactly two reels are equal.
  - win = 0 otherwise.
- done=1 only in the first IDLE cycle after EVAL; busy is 0 in that same cycle. A spin presented in that cycle is accepted.
- Latency: spin sampled at edge E; captures at E+1, E+2, E+3; step k at edge E+3+STEP_DIV*(k+1); EVAL -> IDLE at the edge after the final step.

Test Plan:
- Reset: assert rst for 2 cycles mid-anything -> reel0/1/2=0, busy=0, done=0, win=0 on the next cycle; state IDLE.
- From reset, rnd held 0, spin pulse at edge E, defaults -> reel0 stops at step 8, reel1 at step 16, reel2 at step 16; final edge E+71; done=1 after edge E+72; reels 0,0,0; win=2; busy high E+1..E+71.
- From reset, rnd held 7, spin -> reel0 stops at step 15, reel1 at step 15, reel2 at step 23; reels 7,7,7; win=3; every reel observed wrapping 7->0 during the spin.
- rnd driven 1,1,2 on capture edges E+1..E+3 -> final reels 1,1,2; win=1; exactly one done pulse.
- rnd 3,5,6 -> reels 3,5,6, win=0. spin held high throughout busy -> no restart and no extra capture; a new spin is accepted in the done cycle.
- Reset asserted at step 10 of a spin -> all outputs 0 on the next cycle, no done pulse; a following spin behaves exactly as the reset-state case.
